// File: rtl/steer_pkg.sv
// Shared types and default constants for the rider-detect / steering-enable controller.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_STEER = 2'd2;

  localparam int unsigned LD_W_DEF             = 32'd12;
  localparam int unsigned MIN_RIDER_WEIGHT_DEF = 32'h0000_0200;
  localparam int unsigned HYSTERESIS_DEF       = 32'h0000_0040;
  localparam int unsigned TMR_W_DEF            = 32'd26;

  // FAST_SIM shortens the full-count test to 15 bits, bounded by the counter width.
  function automatic int unsigned full_bits(input int unsigned tmr_w, input int unsigned fast_sim);
    if ((fast_sim != 32'd0) && (tmr_w > 32'd15)) begin
      return 32'd15;
    end else begin
      return tmr_w;
    end
  endfunction

endpackage

// File: rtl/steer_tmr.sv
// Clearable, enabled, saturating settle counter with a full flag.
module steer_tmr
  import steer_pkg::*;
#(
  parameter int unsigned TMR_W    = TMR_W_DEF,
  parameter int unsigned FAST_SIM = 32'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tmr_full
);

  localparam int unsigned FULL_W = full_bits(TMR_W, FAST_SIM);

  logic [TMR_W-1:0] cnt_r;
  logic             full_s;

  assign full_s   = &cnt_r[FULL_W-1:0];
  assign tmr_full = full_s;

  // Counter register: clear wins over increment, and it never advances past full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (en && !full_s) begin
      cnt_r <= cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/steer_en_hyst.sv
// Rider qualification with two-sided weight hysteresis, balance settle timer and steering enable.
module steer_en_hyst
  import steer_pkg::*;
#(
  parameter int unsigned   LD_W             = LD_W_DEF,
  parameter logic [LD_W:0] MIN_RIDER_WEIGHT = (LD_W+1)'(MIN_RIDER_WEIGHT_DEF),
  parameter logic [LD_W:0] HYSTERESIS       = (LD_W+1)'(HYSTERESIS_DEF),
  parameter int unsigned   TMR_W            = TMR_W_DEF,
  parameter int unsigned   FAST_SIM         = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LD_W-1:0]   lft_ld,
  input  logic [LD_W-1:0]   rght_ld,
  output logic              en_steer,
  output logic              rider_off,
  output logic [LD_W:0]     ld_cell_diff,
  output logic [1:0]        steer_state
);

  localparam int unsigned   CW    = LD_W + 5;
  localparam logic [LD_W:0] HI_TH = MIN_RIDER_WEIGHT + HYSTERESIS;
  localparam logic [LD_W:0] LO_TH = MIN_RIDER_WEIGHT - HYSTERESIS;

  logic [LD_W:0]   sum_s;
  logic [LD_W-1:0] abs_diff_s;
  logic [CW-1:0]   sum_w_s;
  logic [CW-1:0]   abs_x4_s;
  logic [CW-1:0]   abs_x16_s;
  logic [CW-1:0]   sum_x15_s;
  logic            sum_gt_min_s;
  logic            sum_lt_min_s;
  logic            balanced_s;
  logic            unbalanced_s;
  logic [1:0]      state_r;
  logic [1:0]      nxt_state_s;
  logic            tmr_clr_s;
  logic            tmr_en_s;
  logic            tmr_full_s;
  logic            rider_off_r;
  logic            rider_off_nxt_s;

  assign sum_s        = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign ld_cell_diff = {1'b0, lft_ld} - {1'b0, rght_ld};
  assign abs_diff_s   = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);

  assign sum_gt_min_s = (sum_s > HI_TH);
  assign sum_lt_min_s = (sum_s < LO_TH);

  // Ratio tests done as widened multiplies so nothing overflows and no divider is needed.
  assign sum_w_s      = CW'(sum_s);
  assign abs_x4_s     = CW'({abs_diff_s, 2'b00});
  assign abs_x16_s    = CW'({abs_diff_s, 4'b0000});
  assign sum_x15_s    = (sum_w_s << 4) - sum_w_s;
  assign balanced_s   = (abs_x4_s < sum_w_s);
  assign unbalanced_s = (abs_x16_s > sum_x15_s);

  steer_tmr #(
    .TMR_W    (TMR_W),
    .FAST_SIM (FAST_SIM)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr_s),
    .en       (tmr_en_s),
    .tmr_full (tmr_full_s)
  );

  // Next-state and timer-control decode; losing the rider always beats the balance checks.
  always_comb begin
    nxt_state_s = state_r;
    tmr_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sum_gt_min_s) begin
          nxt_state_s = ST_WAIT;
          tmr_clr_s   = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (sum_lt_min_s) begin
          nxt_state_s = ST_IDLE;
        end else if (!balanced_s) begin
          nxt_state_s = ST_WAIT;
          tmr_clr_s   = 1'b1;
        end else if (tmr_full_s) begin
          nxt_state_s = ST_STEER;
        end else begin
          nxt_state_s = ST_WAIT;
        end
      end
      ST_STEER: begin
        if (sum_lt_min_s) begin
          nxt_state_s = ST_IDLE;
        end else if (unbalanced_s) begin
          nxt_state_s = ST_WAIT;
          tmr_clr_s   = 1'b1;
        end else begin
          nxt_state_s = ST_STEER;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  assign tmr_en_s        = (state_r == ST_WAIT) && (nxt_state_s == ST_WAIT);
  assign rider_off_nxt_s = ((state_r == ST_WAIT) || (state_r == ST_STEER)) &&
                           (nxt_state_s == ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Rider-off pulse rises on the same edge that lands in IDLE from an occupied state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rider_off_r <= 1'b0;
    end else begin
      rider_off_r <= rider_off_nxt_s;
    end
  end

  assign en_steer    = (state_r == ST_STEER);
  assign rider_off   = rider_off_r;
  assign steer_state = state_r;

endmodule

// File: tb/tb_steer_en_hyst.sv
// Directed bench for steer_en_hyst: vector table plus multi-cycle settle, restart and exit sequences.
module tb_steer_en_hyst;

  typedef struct {
    logic [11:0] lft;
    logic [11:0] rght;
    logic [1:0]  st;
    logic        en;
    logic        off;
    logic [12:0] diff;
  } vec_t;

  // 32767 counting cycles after the clear, plus the edge that samples tmr_full.
  localparam int SETTLE_EDGES = 32768;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_b;
  logic [11:0] lft, rght, lft_b, rght_b;
  logic        en_steer, rider_off, en_steer_b, rider_off_b;
  logic [12:0] ld_cell_diff, ld_cell_diff_b;
  logic [1:0]  steer_state, steer_state_b;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  steer_en_hyst #(.LD_W(12), .MIN_RIDER_WEIGHT(13'h200), .HYSTERESIS(13'h040),
                  .TMR_W(26), .FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .lft_ld(lft), .rght_ld(rght),
    .en_steer(en_steer), .rider_off(rider_off),
    .ld_cell_diff(ld_cell_diff), .steer_state(steer_state));

  steer_en_hyst #(.LD_W(12), .MIN_RIDER_WEIGHT(13'h200), .HYSTERESIS(13'h040),
                  .TMR_W(26), .FAST_SIM(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .lft_ld(lft_b), .rght_ld(rght_b),
    .en_steer(en_steer_b), .rider_off(rider_off_b),
    .ld_cell_diff(ld_cell_diff_b), .steer_state(steer_state_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the selected DUT raises en_steer, bounded.
  task automatic wait_steer(input bit sel_b, output int n);
    n = 0;
    for (int i = 0; i < 40000; i++) begin
      step();
      n++;
      if ((sel_b ? en_steer_b : en_steer) == 1'b1) break;
    end
    if ((sel_b ? en_steer_b : en_steer) != 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_steer_timeout actual=%0d required=%0d", n, SETTLE_EDGES);
    end
  endtask

  initial begin
    vecs[0]  = '{12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 13'h0000};
    vecs[1]  = '{12'h0E8, 12'h0E8, 2'd0, 1'b0, 1'b0, 13'h0000};
    vecs[2]  = '{12'h128, 12'h128, 2'd1, 1'b0, 1'b0, 13'h0000};
    vecs[3]  = '{12'h0E8, 12'h0E8, 2'd1, 1'b0, 1'b0, 13'h0000};
    vecs[4]  = '{12'h0D8, 12'h0D8, 2'd0, 1'b0, 1'b1, 13'h0000};
    vecs[5]  = '{12'h0D8, 12'h0D8, 2'd0, 1'b0, 1'b0, 13'h0000};
    vecs[6]  = '{12'h000, 12'hFFF, 2'd1, 1'b0, 1'b0, 13'h1001};
    vecs[7]  = '{12'h100, 12'h0C0, 2'd1, 1'b0, 1'b0, 13'h0040};
    vecs[8]  = '{12'h0BF, 12'h100, 2'd0, 1'b0, 1'b1, 13'h1FBF};
    vecs[9]  = '{12'h120, 12'h120, 2'd0, 1'b0, 1'b0, 13'h0000};
    vecs[10] = '{12'h121, 12'h120, 2'd1, 1'b0, 1'b0, 13'h0001};
    vecs[11] = '{12'h000, 12'h000, 2'd0, 1'b0, 1'b1, 13'h0000};
    vecs[12] = '{12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 13'h0000};

    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    lft     = 12'h000;
    rght    = 12'h000;
    lft_b   = 12'h200;
    rght_b  = 12'h0A0;
    #12;

    fork
      begin : main_seq
        int n;
        chk("reset_outputs", {29'd0, steer_state, en_steer}, 32'd0);
        chk("reset_rider_off", {31'd0, rider_off}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
          step();
          chk("idle_hold", {16'd0, steer_state, en_steer, rider_off, ld_cell_diff}, 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
          lft  = vecs[i].lft;
          rght = vecs[i].rght;
          step();
          chk($sformatf("vec%0d_state", i), {30'd0, steer_state}, {30'd0, vecs[i].st});
          chk($sformatf("vec%0d_en", i), {31'd0, en_steer}, {31'd0, vecs[i].en});
          chk($sformatf("vec%0d_off", i), {31'd0, rider_off}, {31'd0, vecs[i].off});
          chk($sformatf("vec%0d_diff", i), {19'd0, ld_cell_diff}, {19'd0, vecs[i].diff});
        end

        lft  = 12'h150;
        rght = 12'h150;
        step();
        chk("settle_entry_state", {30'd0, steer_state}, 32'd1);
        wait_steer(1'b0, n);
        chk("settle_edges", n, SETTLE_EDGES);
        chk("settle_state", {30'd0, steer_state}, 32'd2);

        lft  = 12'h3F0;
        rght = 12'h010;
        step();
        chk("unbal_exit_state", {30'd0, steer_state}, 32'd1);
        chk("unbal_exit_en", {31'd0, en_steer}, 32'd0);
        chk("unbal_exit_off", {31'd0, rider_off}, 32'd0);

        lft  = 12'h150;
        rght = 12'h150;
        repeat (1000) step();
        chk("pre_glitch_state", {30'd0, steer_state}, 32'd1);
        lft  = 12'h200;
        rght = 12'h0A0;
        step();
        chk("glitch_state", {30'd0, steer_state}, 32'd1);
        lft  = 12'h150;
        rght = 12'h150;
        wait_steer(1'b0, n);
        chk("restart_edges", n, SETTLE_EDGES);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", {31'd0, en_steer}, 32'd0);
        chk("async_rst_state", {30'd0, steer_state}, 32'd0);
        chk("async_rst_off", {31'd0, rider_off}, 32'd0);
        lft  = 12'h000;
        rght = 12'h000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_off", {31'd0, rider_off}, 32'd0);
        chk("post_rst_state", {30'd0, steer_state}, 32'd0);
      end

      begin : side_seq
        int n;
        int hi;
        @(negedge clk);
        rst_n_b = 1'b1;
        step();
        chk("b_entry_state", {30'd0, steer_state_b}, 32'd1);
        hi = 0;
        for (int i = 0; i < 32900; i++) begin
          step();
          if (en_steer_b) hi++;
        end
        chk("b_unbal_no_steer", hi, 32'd0);
        chk("b_unbal_state", {30'd0, steer_state_b}, 32'd1);

        lft_b  = 12'h150;
        rght_b = 12'h150;
        wait_steer(1'b1, n);
        chk("b_settle_edges", n, SETTLE_EDGES);

        lft_b  = 12'h000;
        rght_b = 12'h000;
        step();
        chk("b_exit_state", {30'd0, steer_state_b}, 32'd0);
        chk("b_exit_en", {31'd0, en_steer_b}, 32'd0);
        chk("b_exit_off", {31'd0, rider_off_b}, 32'd1);
        step();
        chk("b_off_fall", {31'd0, rider_off_b}, 32'd0);
        chk("b_idle_state", {30'd0, steer_state_b}, 32'd0);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
